seq_sgn_div: RTL and testbench

Iterative signed divider for the fixed-point feature datapath. It is the division counterpart of the approximate signed multiplier. It works in sign-magnitude form: operand magnitudes are formed first, quotient and remainder magnitudes are produced by restoring division at one bit per clock, and the signs are re-applied on output. Upstream and downstream stages connect through valid/ready handshakes.

---
 rtl/sift_arith_pkg.sv | 19 +
 rtl/seq_sgn_div_if.sv | 41 ++++
 rtl/seq_sgn_div_abs_sat.sv | 29 ++
 rtl/seq_sgn_div.sv | 145 ++++++++++++++
 tb/tb_seq_sgn_div.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sift_arith_pkg.sv
// Shared arithmetic helpers for the fixed-point feature datapath.
// FSM state encoding and width/saturation constant functions.
package sift_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int magW(input int dataW);
    return dataW - 1;
  endfunction

  function automatic int satMax(input int dataW);
    return (1 << (dataW - 1)) - 1;
  endfunction

endpackage

// File: rtl/seq_sgn_div_if.sv
// Operand/result handshake bundle for seq_sgn_div.
// master drives operands and out_ready; slave is the divider.
interface seq_sgn_div_if #(
  parameter int dataW = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [dataW-1:0] dividend;
  logic signed [dataW-1:0] divisor;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [dataW-1:0] quotient;
  logic signed [dataW-1:0] remainder;
  logic                    div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_sgn_div_abs_sat.sv
// Signed-to-magnitude conversion with saturation of the most
// negative value, so the magnitude always fits dataW-1 bits.
module abs_sat
  import sift_arith_pkg::*;
#(
  parameter int dataW = 8,
  localparam int M = magW(dataW)
) (
  input  logic signed [dataW-1:0] val_i,
  output logic        [M-1:0]     mag_o
);

  localparam int SAT = satMax(dataW);
  localparam logic [M-1:0] MAX = SAT[M-1:0];

  logic [dataW-1:0] neg;

  always_comb begin
    neg = -val_i;
    if (!val_i[dataW-1]) begin
      mag_o = val_i[M-1:0];
    end else if (val_i[M-1:0] == '0) begin
      mag_o = MAX;
    end else begin
      mag_o = neg[M-1:0];
    end
  end

endmodule

// File: rtl/seq_sgn_div.sv
// Iterative sign-magnitude restoring divider, one quotient
// bit per clock, valid/ready on both sides.
module seq_sgn_div
  import sift_arith_pkg::*;
#(
  parameter int dataW = 8
) (
  input logic clk,
  input logic rst_n,
  seq_sgn_div_if.slave bus
);

  localparam int M = magW(dataW);
  localparam int CW = $clog2(M + 1);
  localparam int SAT = satMax(dataW);
  localparam logic [CW-1:0] LAST = CW'(M - 1);
  localparam logic [dataW-1:0] MAXE = SAT[dataW-1:0];

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [M-1:0]     dvd_q, dvd_d;
  logic [M-1:0]     dvs_q, dvs_d;
  logic [M:0]       prem_q, prem_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic             dz_q, dz_d;
  logic [dataW-1:0] quo_q, quo_d;
  logic [dataW-1:0] rem_q, rem_d;
  logic             dzo_q, dzo_d;

  logic [M-1:0]     amag, bmag;
  logic [M:0]       sh, diff;
  logic             ge;
  logic [M-1:0]     qmag, rmag;
  logic [dataW-1:0] qext, rext;

  abs_sat #(.dataW(dataW)) u_abs_dvd (
    .val_i (bus.dividend),
    .mag_o (amag)
  );

  abs_sat #(.dataW(dataW)) u_abs_dvs (
    .val_i (bus.divisor),
    .mag_o (bmag)
  );

  // dvd_q shifts the dividend out at the top and the
  // quotient bits in at the bottom.
  always_comb begin
    sh   = {prem_q[M-1:0], dvd_q[M-1]};
    ge   = (sh >= {1'b0, dvs_q});
    diff = ge ? (sh - {1'b0, dvs_q}) : sh;
    qmag = {dvd_q[M-2:0], ge};
    rmag = diff[M-1:0];
    qext = {1'b0, qmag};
    rext = {1'b0, rmag};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          dvd_d   = amag;
          dvs_d   = bmag;
          prem_d  = '0;
          sgnq_d  = bus.dividend[dataW-1] ^ bus.divisor[dataW-1];
          sgnr_d  = bus.dividend[dataW-1];
          dz_d    = (bus.divisor == '0);
        end
      end
      CALC: begin
        prem_d = diff;
        dvd_d  = qmag;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          // A zero divisor leaves the dividend magnitude as remainder.
          if (dz_q) begin
            quo_d = sgnr_q ? -MAXE : MAXE;
          end else begin
            quo_d = sgnq_q ? -qext : qext;
          end
          rem_d = sgnr_q ? -rext : rext;
          dzo_d = dz_q;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_sgn_div.sv
// Directed and random checks of seq_sgn_div against an
// integer-arithmetic reference model (dataW = 8).
module tb_seq_sgn_div;

  localparam int DW   = 8;
  localparam int MAXV = 127;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  seq_sgn_div_if #(.dataW(DW)) bus ();

  seq_sgn_div #(.dataW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int a, input int b,
                                output int q, output int r,
                                output int z);
    int ca;
    int cb;
    ca = (a == -128) ? -MAXV : a;
    cb = (b == -128) ? -MAXV : b;
    z  = (b == 0) ? 1 : 0;
    if (b == 0) begin
      q = (a >= 0) ? MAXV : -MAXV;
      r = ca;
    end else begin
      q = ca / cb;
      r = ca % cb;
    end
  endfunction

  task automatic send(input int a, input int b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("in_ready_timeout", 0, 1);
    bus.dividend = DW'(a);
    bus.divisor  = DW'(b);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic check_res(input string tag, input int a, input int b);
    int q, r, z;
    model(a, b, q, r, z);
    chk({tag, "_ov"}, int'(bus.out_valid), 1);
    chk({tag, "_q"}, int'(bus.quotient), q);
    chk({tag, "_r"}, int'(bus.remainder), r);
    chk({tag, "_dz"}, int'(bus.div_by_zero), z);
  endtask

  task automatic div(input string tag, input int a, input int b,
                     input bit chk_lat);
    int lat;
    send(a, b);
    wait_out(lat);
    if (chk_lat) chk({tag, "_lat"}, lat, 8);
    check_res(tag, a, b);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, q0, r0, hi, a, b, w;
    n_assert = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_q", int'(bus.quotient), 0);
    chk("rst_r", int'(bus.remainder), 0);
    chk("rst_dz", int'(bus.div_by_zero), 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    div("p100_7", 100, 7, 1);
    div("n100_7", -100, 7, 0);
    div("p100_n7", 100, -7, 0);
    div("n100_n7", -100, -7, 0);
    div("p5_0", 5, 0, 1);
    div("n5_0", -5, 0, 1);
    div("n128_1", -128, 1, 0);
    div("p127_127", 127, 127, 0);
    div("p3_100", 3, 100, 0);
    div("z_n9", 0, -9, 0);
    div("n128_0", -128, 0, 0);
    div("n128_n128", -128, -128, 0);

    // Back-pressure with a pending operand pair.
    send(-77, 5);
    wait_out(lat);
    bus.out_ready = 1'b0;
    bus.dividend  = 8'sd9;
    bus.divisor   = 8'sd2;
    bus.in_valid  = 1'b1;
    q0 = int'(bus.quotient);
    r0 = int'(bus.remainder);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ov", int'(bus.out_valid), 1);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_q_hold", int'(bus.quotient), q0);
      chk("bp_r_hold", int'(bus.remainder), r0);
    end
    check_res("bp", -77, 5);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", int'(bus.in_ready), 1);
    chk("bp_idle_ov", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_accepted", int'(bus.in_ready), 0);
    wait_out(lat);
    chk("bp_next_lat", lat, 8);
    check_res("bp_next", 9, 2);
    @(posedge clk); #1;

    // Reset during the fourth iteration.
    send(100, 7);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_ov", int'(bus.out_valid), 0);
    chk("mid_rst_q", int'(bus.quotient), 0);
    chk("mid_rst_r", int'(bus.remainder), 0);
    chk("mid_rst_dz", int'(bus.div_by_zero), 0);
    #4 rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) hi++;
    end
    chk("mid_rst_no_ov", hi, 0);
    div("p50_5", 50, 5, 1);

    // Random operands with random consumer stalls.
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(255, 0)) - 128;
      b = ($urandom_range(7, 0) == 0) ? 0
        : int'($urandom_range(255, 0)) - 128;
      send(a, b);
      wait_out(lat);
      chk("rnd_lat", lat, 8);
      w = int'($urandom_range(2, 0));
      if (w != 0) begin
        bus.out_ready = 1'b0;
        repeat (w) @(posedge clk);
        #1;
      end
      check_res("rnd", a, b);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
